// File: rtl/htif_mem_initiator.sv
// htif_mem_initiator: host-side initiator for the HTIF memory port.
// Host side: host_cmd_* (rw/addr command), host_wdata_* (4 words per write line),
//            host_rdata_* (4 words per read line, word 0 first), error/error_clr (sticky abort flag).
// Memory side: htif_req_* (one outstanding request, rolling tag), htif_resp_* (tagged load data or nack).
module htif_mem_initiator #(
  parameter int TAG_W     = 4,
  parameter int MAX_RETRY = 7,
  parameter int TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             host_cmd_val,
  output logic             host_cmd_rdy,
  input  logic             host_cmd_rw,
  input  logic [13:0]      host_cmd_addr,
  input  logic             host_wdata_val,
  output logic             host_wdata_rdy,
  input  logic [31:0]      host_wdata,
  output logic             host_rdata_val,
  input  logic             host_rdata_rdy,
  output logic [31:0]      host_rdata,
  output logic             error,
  input  logic             error_clr,
  output logic             htif_req_val,
  input  logic             htif_req_rdy,
  output logic             htif_req_rw,
  output logic [13:0]      htif_req_addr,
  output logic [127:0]     htif_req_data,
  output logic [TAG_W-1:0] htif_req_tag,
  input  logic             htif_resp_val,
  input  logic             htif_resp_nack,
  input  logic [127:0]     htif_resp_data,
  input  logic [TAG_W-1:0] htif_resp_tag
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, GATHER, REQ, WAIT, DRAIN} state_t;
  state_t           r_state, w_next;
  logic             r_cmd_rdy, r_rw, r_error;
  logic [13:0]      r_addr;
  logic [127:0]     r_line;
  logic [TAG_W-1:0] r_tag, r_exp;
  logic [RW-1:0]    r_retry;
  logic [TW-1:0]    r_timer;
  logic [1:0]       r_idx;
  logic             w_cmd_hs, w_wd_hs, w_req_hs, w_match, w_bad, w_ack, w_retry, w_abort, w_rd_hs;
  always_comb begin
    w_cmd_hs = r_cmd_rdy & host_cmd_val;
    w_wd_hs  = (r_state == GATHER) & host_wdata_val;
    w_req_hs = (r_state == REQ) & htif_req_rdy;
    w_match  = (r_state == WAIT) & htif_resp_val & (htif_resp_tag == r_exp);
    w_bad    = (r_state == WAIT) & htif_resp_val & (htif_resp_tag != r_exp);
    w_ack    = w_match & ~htif_resp_nack;
    w_retry  = w_match & htif_resp_nack & (r_retry < RW'(MAX_RETRY));
    // a matching response takes priority over a timeout in the same cycle
    w_abort  = (w_match & htif_resp_nack & ~w_retry) |
               ((r_state == WAIT) & ~w_match & (r_timer == TW'(TIMEOUT)));
    w_rd_hs  = (r_state == DRAIN) & host_rdata_rdy;
    w_next   = r_state;
    case (r_state)
      IDLE:    w_next = w_cmd_hs ? (host_cmd_rw ? GATHER : REQ) : IDLE;
      GATHER:  w_next = (w_wd_hs && r_idx == 2'd3) ? REQ : GATHER;
      REQ:     w_next = w_req_hs ? (r_rw ? IDLE : WAIT) : REQ;
      WAIT:    w_next = w_retry ? REQ : (w_ack | w_abort) ? DRAIN : WAIT;
      DRAIN:   w_next = (w_rd_hs && r_idx == 2'd3) ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // cmd_rdy is registered so it stays low while reset is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cmd_rdy <= 1'b0;
      r_rw      <= 1'b0;
      r_addr    <= '0;
      r_line    <= '0;
      r_tag     <= '0;
      r_exp     <= '0;
      r_retry   <= '0;
      r_timer   <= '0;
      r_idx     <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cmd_rdy <= (w_next == IDLE);
      r_error   <= w_bad | w_abort | (r_error & ~error_clr);
      if (w_cmd_hs) begin
        r_rw    <= host_cmd_rw;
        r_addr  <= host_cmd_addr;
        r_idx   <= '0;
        r_retry <= '0;
      end
      if (w_wd_hs) begin
        r_line[{r_idx, 5'b0} +: 32] <= host_wdata;
        r_idx <= r_idx + 2'd1;
      end
      if (w_req_hs) begin
        r_tag   <= r_tag + 1'b1;
        r_exp   <= r_tag;
        r_timer <= '0;
      end
      if (r_state == WAIT) r_timer <= r_timer + 1'b1;
      if (w_retry) r_retry <= r_retry + 1'b1;
      if (w_ack) r_line <= htif_resp_data;
      if (w_abort) r_line <= '0;
      if (w_ack | w_abort) r_idx <= '0;
      if (w_rd_hs) r_idx <= r_idx + 2'd1;
    end
  end
  assign host_cmd_rdy   = r_cmd_rdy;
  assign host_wdata_rdy = (r_state == GATHER);
  assign host_rdata_val = (r_state == DRAIN);
  assign host_rdata     = r_line[{r_idx, 5'b0} +: 32];
  assign error          = r_error;
  assign htif_req_val   = (r_state == REQ);
  assign htif_req_rw    = r_rw;
  assign htif_req_addr  = r_addr;
  assign htif_req_data  = r_line;
  assign htif_req_tag   = r_tag;
endmodule

// File: tb/tb_htif_mem_initiator.sv
// tb_htif_mem_initiator: directed plus randomized checks of htif_mem_initiator against a line-level memory model.
module tb_htif_mem_initiator;
  localparam int TAG_W = 4, MAX_RETRY = 7, TIMEOUT = 1023;
  logic clk = 1'b0, reset_n = 1'b1;
  logic host_cmd_val = 0, host_cmd_rdy, host_cmd_rw = 0;
  logic [13:0] host_cmd_addr = '0;
  logic host_wdata_val = 0, host_wdata_rdy;
  logic [31:0] host_wdata = '0;
  logic host_rdata_val, host_rdata_rdy = 0;
  logic [31:0] host_rdata;
  logic error, error_clr = 0;
  logic htif_req_val, htif_req_rdy = 0, htif_req_rw;
  logic [13:0] htif_req_addr;
  logic [127:0] htif_req_data;
  logic [TAG_W-1:0] htif_req_tag;
  logic htif_resp_val = 0, htif_resp_nack = 0;
  logic [127:0] htif_resp_data = '0;
  logic [TAG_W-1:0] htif_resp_tag = '0;
  int n_chk = 0, n_err = 0;
  logic [TAG_W-1:0] m_tag = '0;
  logic m_err = 1'b0;
  logic [127:0] mem [logic [13:0]];

  htif_mem_initiator #(.TAG_W(TAG_W), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .host_cmd_val(host_cmd_val), .host_cmd_rdy(host_cmd_rdy), .host_cmd_rw(host_cmd_rw), .host_cmd_addr(host_cmd_addr),
    .host_wdata_val(host_wdata_val), .host_wdata_rdy(host_wdata_rdy), .host_wdata(host_wdata),
    .host_rdata_val(host_rdata_val), .host_rdata_rdy(host_rdata_rdy), .host_rdata(host_rdata),
    .error(error), .error_clr(error_clr),
    .htif_req_val(htif_req_val), .htif_req_rdy(htif_req_rdy), .htif_req_rw(htif_req_rw),
    .htif_req_addr(htif_req_addr), .htif_req_data(htif_req_data), .htif_req_tag(htif_req_tag),
    .htif_resp_val(htif_resp_val), .htif_resp_nack(htif_resp_nack), .htif_resp_data(htif_resp_data),
    .htif_resp_tag(htif_resp_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return host_cmd_rdy;
      1: return host_wdata_rdy;
      2: return htif_req_val;
      3: return host_rdata_val;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string t, input int w);
    int n = 0;
    while (sig(w) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(t, 128'(sig(w)), 128'(1));
  endtask

  task automatic send_cmd(input logic rw, input logic [13:0] a);
    host_cmd_val = 1; host_cmd_rw = rw; host_cmd_addr = a;
    wait_for("cmd_rdy", 0);
    @(negedge clk);
    host_cmd_val = 0;
  endtask

  task automatic issue_req(input logic rw, input logic [13:0] a, input logic [127:0] d, output logic [TAG_W-1:0] sent);
    int dly;
    wait_for("req_val", 2);
    chk("req_rw", 128'(htif_req_rw), 128'(rw));
    chk("req_addr", 128'(htif_req_addr), 128'(a));
    chk("req_tag", 128'(htif_req_tag), 128'(m_tag));
    if (rw) chk("req_data", htif_req_data, d);
    dly = $urandom_range(0, 2);
    repeat (dly) begin
      @(negedge clk);
      chk("req_hold", 128'({htif_req_val, htif_req_tag, htif_req_addr}), 128'({1'b1, m_tag, a}));
    end
    htif_req_rdy = 1;
    @(negedge clk);
    htif_req_rdy = 0;
    sent = m_tag;
    m_tag = m_tag + 1'b1;
  endtask

  task automatic drain(input logic [127:0] l);
    for (int k = 0; k < 4; k++) begin
      wait_for("rdata_val", 3);
      if (k % 2 == 0 || $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("rdata_stall", 128'({host_rdata_val, host_rdata}), 128'({1'b1, l[32*k +: 32]}));
      end
      chk("rdata", 128'(host_rdata), 128'(l[32*k +: 32]));
      host_rdata_rdy = 1;
      @(negedge clk);
      host_rdata_rdy = 0;
    end
    chk("idle_after_rd", 128'(host_cmd_rdy), 128'(1));
  endtask

  task automatic do_write(input logic [13:0] a, input logic [127:0] l);
    logic [TAG_W-1:0] s;
    send_cmd(1'b1, a);
    for (int k = 0; k < 4; k++) begin
      host_wdata_val = 1; host_wdata = l[32*k +: 32];
      wait_for("wdata_rdy", 1);
      @(negedge clk);
      host_wdata_val = 0;
    end
    issue_req(1'b1, a, l, s);
    chk("idle_after_wr", 128'(host_cmd_rdy), 128'(1));
    mem[a] = l;
  endtask

  task automatic do_read(input logic [13:0] a, input int nacks, input logic [127:0] l);
    logic [TAG_W-1:0] s;
    int att, dly;
    att = (nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1;
    send_cmd(1'b0, a);
    for (int i = 0; i < att; i++) begin
      issue_req(1'b0, a, '0, s);
      dly = $urandom_range(1, 3);
      repeat (dly) begin
        chk("wait_quiet", 128'({htif_req_val, host_rdata_val}), 128'(0));
        @(negedge clk);
      end
      htif_resp_val = 1; htif_resp_tag = s; htif_resp_nack = (i < nacks); htif_resp_data = l;
      @(negedge clk);
      htif_resp_val = 0; htif_resp_nack = 0;
    end
    if (nacks > MAX_RETRY) m_err = 1'b1;
    chk("error", 128'(error), 128'(m_err));
    drain((nacks > MAX_RETRY) ? 128'(0) : l);
  endtask

  task automatic pulse_reset();
    reset_n = 0;
    #1;
    chk("rst_outs", 128'({host_cmd_rdy, host_wdata_rdy, htif_req_val, host_rdata_val, error}), 128'(0));
    chk("rst_tag", 128'(htif_req_tag), 128'(0));
    @(negedge clk);
    reset_n = 1;
    m_tag = '0; m_err = 1'b0;
    host_cmd_val = 0; host_wdata_val = 0; htif_req_rdy = 0; htif_resp_val = 0; host_rdata_rdy = 0;
    @(negedge clk);
    chk("rst_idle", 128'(host_cmd_rdy), 128'(1));
  endtask

  initial begin
    logic [TAG_W-1:0] s;
    logic [127:0] l;
    logic [13:0] a;
    int cnt;
    #1;
    pulse_reset();
    do_write(14'h0123, 128'h44444444_33333333_22222222_11111111);
    do_read(14'h0010, 0, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    do_read(14'h0123, 2, mem[14'h0123]);
    do_read(14'h0055, 8, {$urandom, $urandom, $urandom, $urandom});
    send_cmd(1'b0, 14'h0222);
    issue_req(1'b0, 14'h0222, '0, s);
    cnt = 0;
    while (host_rdata_val !== 1'b1 && cnt < 2000) begin
      if (cnt == 100) begin
        htif_resp_val = 1; htif_resp_tag = s + 1'b1; error_clr = 1;
      end else if (cnt == 200) error_clr = 1;
      @(negedge clk);
      cnt++;
      htif_resp_val = 0; error_clr = 0;
      if (cnt == 101) chk("bad_tag_set_wins", 128'({error, host_rdata_val}), 128'(2'b10));
      if (cnt == 201) chk("err_clr_in_wait", 128'(error), 128'(0));
    end
    chk("timeout_cycles", 128'(cnt), 128'(TIMEOUT + 1));
    chk("timeout_err", 128'(error), 128'(1));
    m_err = 1'b1;
    drain('0);
    error_clr = 1;
    @(negedge clk);
    error_clr = 0;
    m_err = 1'b0;
    chk("err_clr", 128'(error), 128'(0));
    send_cmd(1'b1, 14'h0301);
    for (int k = 0; k < 2; k++) begin
      host_wdata_val = 1; host_wdata = $urandom;
      wait_for("wdata_rdy", 1);
      @(negedge clk);
      host_wdata_val = 0;
    end
    chk("gather_busy", 128'(host_wdata_rdy), 128'(1));
    pulse_reset();
    send_cmd(1'b0, 14'h0302);
    issue_req(1'b0, 14'h0302, '0, s);
    htif_resp_val = 1; htif_resp_tag = s + 1'b1;
    @(negedge clk);
    htif_resp_val = 0;
    chk("wait_bad_tag", 128'({error, host_rdata_val}), 128'(2'b10));
    pulse_reset();
    for (int it = 0; it < 10; it++) begin
      a = 14'h0100 + 14'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        l = {$urandom, $urandom, $urandom, $urandom};
        do_write(a, l);
      end else begin
        l = mem.exists(a) ? mem[a] : {$urandom, $urandom, $urandom, $urandom};
        do_read(a, $urandom_range(0, 2), l);
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/htif_mem_initiator.md
Name: htif_mem_initiator

Overview:
- Host-side initiator for the HTIF memory port of the chip top.
- Accepts host read/write commands on a 32-bit word stream.
- For writes, assembles 4 host words into one 128-bit line; for reads, splits the 128-bit response into 4 words.
- Drives the top's htif_req_*/htif_resp_* interface: one outstanding request, rolling tag, nack retry, response timeout, sticky error flag.

Parameters:
- TAG_W, 4: request/response tag width; must equal `MEM_TAG_BITS.
- MAX_RETRY, 7: nacks tolerated per read before abort.
- TIMEOUT, 1023: cycles waited in WAIT before abort.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- host_cmd_val  in  1  command valid
- host_cmd_rdy  out  1  command accepted
- host_cmd_rw  in  1  1=write, 0=read
- host_cmd_addr  in  14  line address
- host_wdata_val  in  1  write word valid
- host_wdata_rdy  out  1  write word accepted
- host_wdata  in  32  write word
- host_rdata_val  out  1  read word valid
- host_rdata_rdy  in  1  read word accepted
- host_rdata  out  32  read word
- error  out  1  sticky abort flag
- error_clr  in  1  clears error
- htif_req_val  out  1  memory request valid
- htif_req_rdy  in  1  memory request accepted
- htif_req_rw  out  1  1=store
- htif_req_addr  out  14  line address
- htif_req_data  out  128  store line
- htif_req_tag  out  TAG_W  request tag
- htif_resp_val  in  1  response valid
- htif_resp_nack  in  1  response is a nack
- htif_resp_data  in  128  load line
- htif_resp_tag  in  TAG_W  response tag

Behaviour:
- Reset (reset_n=0, async): state=IDLE; all *_val/*_rdy outputs 0; error=0; tag counter=0; retry=0; timer=0; word index=0; data registers 0.
- FSM states: IDLE, GATHER, REQ, WAIT, DRAIN.
- IDLE:
  - host_cmd_rdy=1.
  - On cmd handshake, latch rw and addr.
  - Write goes to GATHER (index=0); read goes to REQ (retry=0).
- GATHER:
  - host_wdata_rdy=1.
  - Word k lands in line bits [32k+31:32k], k=0..3.
  - After word 3 handshake, go to REQ.
- REQ:
  - htif_req_val=1; addr, rw, data and tag held stable until htif_req_rdy.
  - On handshake, the tag counter increments (wraps mod 2^TAG_W).
  - A write then returns to IDLE; writes complete on acceptance and expect no response.
  - A read goes to WAIT with timer=0; the expected tag is the value sent.
- WAIT (reads only):
  - Timer increments each cycle.
  - resp_val with tag==expected and nack=0: latch data, index=0, go to DRAIN.
  - resp_val with tag==expected and nack=1: if retry<MAX_RETRY, retry++ and return to REQ, reissuing with a fresh tag. Otherwise set error, load line=0, go to DRAIN.
  - resp_val with a mismatched tag: ignore it and set error; the timer keeps running.
  - timer==TIMEOUT: set error, load line=0, go to DRAIN.
  - When a matching response and a timeout land in the same cycle, the response wins.
- DRAIN:
  - host_rdata_val=1, host_rdata = line word[index], word 0 first.
  - index advances on each rdy handshake; after word 3, go to IDLE.
  - The host may stall indefinitely.
- error:
  - Set by any abort or mismatched tag.
  - error_clr clears it unless a set event occurs in the same cycle; set wins.
- Exactly one request is outstanding at a time; host_cmd_rdy=0 outside IDLE.
- Outputs are registered or decoded from state only; there is no combinational path from htif_resp_* to host_* outputs.

Test Plan:
- Write addr 0x0123, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with req_rdy=1 → one htif_req: rw=1, addr=0x0123, data=0x44444444_33333333_22222222_11111111, tag=0; FSM back in IDLE the next cycle.
- Read addr 0x0010 after the write; response 2 cycles later with tag=1, data=0xAAAA…_DDDD… → host_rdata gives word 0..3 low-to-high; host_rdata_rdy toggled 1/0 shows stall holding.
- Read nacked twice, then acked → three htif_req issued with tags 2,3,4; data returned from the third; error stays 0.
- Read nacked 8 times (MAX_RETRY=7) → 8 requests issued, error=1, four rdata words of 0x00000000; error_clr then drops error to 0.
- Read with no response → at cycle 1023 of WAIT, error=1 and four zero words are returned. A response with a wrong tag mid-wait sets error but does not end the wait.
- Assert reset_n low during GATHER (2 words taken) and during WAIT → all outputs 0 immediately, tag=0, IDLE with host_cmd_rdy=1 after release.
